riscv_issue: RTL

RISCV_ISSUE -- requirements
Module: riscv_issue

---
 rtl/riscv_issue.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/riscv_issue.sv
// riscv_issue: single-issue stage with load scoreboard, exec bypass and exec/LSU dispatch
module riscv_issue #(
   parameter bit SUPPORT_FWD = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_valid_i,
   input  logic [55:0] fetch_instr_i,
   input  logic [31:0] fetch_opcode_i,
   input  logic [31:0] fetch_pc_i,
   output logic        fetch_accept_o,
   input  logic        branch_request_i,
   input  logic [31:0] branch_pc_i,
   output logic        branch_request_o,
   output logic [31:0] branch_pc_o,
   output logic        exec_opcode_valid_o,
   output logic [55:0] exec_instr_o,
   output logic [31:0] exec_opcode_o,
   output logic [31:0] exec_pc_o,
   output logic [4:0]  exec_rd_idx_o,
   output logic [4:0]  exec_ra_idx_o,
   output logic [4:0]  exec_rb_idx_o,
   output logic [31:0] exec_ra_operand_o,
   output logic [31:0] exec_rb_operand_o,
   input  logic [4:0]  exec_wb_idx_i,
   input  logic [31:0] exec_wb_value_i,
   output logic        lsu_valid_o,
   output logic [55:0] lsu_instr_o,
   output logic [31:0] lsu_opcode_o,
   output logic [31:0] lsu_pc_o,
   output logic [4:0]  lsu_rd_idx_o,
   output logic [31:0] lsu_ra_operand_o,
   output logic [31:0] lsu_rb_operand_o,
   input  logic        lsu_accept_i,
   input  logic        lsu_wb_valid_i,
   input  logic [4:0]  lsu_wb_idx_i,
   input  logic [31:0] lsu_wb_value_i
);
   // one-hot instruction bits: LB/LH/LW/LBU/LHU at 29..33, SB/SH/SW at 35..37
   localparam logic [55:0] LOAD_MASK  = 56'h1f << 29;
   localparam logic [55:0] STORE_MASK = 56'h07 << 35;

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HOLD} state_t;

   state_t      state_q, state_d;
   logic        ir_valid_q;
   logic [31:0] ir_pc_q, ir_opcode_q;
   logic [55:0] ir_instr_q;
   logic [31:0] sb_q, sb_d;
   logic        lsu_busy_q;
   logic [31:0] rf_q [32];
   logic [4:0]  ir_rd, ir_ra, ir_rb, f_rd, f_ra, f_rb;
   logic        ir_load, ir_lsu, f_load, f_lsu;
   logic        stall, hazard, ir_hold, ir_load_en;
   logic [31:0] ra_op, rb_op;

   assign ir_rd = ir_opcode_q[11:7];
   assign ir_ra = ir_opcode_q[19:15];
   assign ir_rb = ir_opcode_q[24:20];
   assign f_rd  = fetch_opcode_i[11:7];
   assign f_ra  = fetch_opcode_i[19:15];
   assign f_rb  = fetch_opcode_i[24:20];

   assign ir_load = |(ir_instr_q & LOAD_MASK);
   assign ir_lsu  = ir_load | (|(ir_instr_q & STORE_MASK));
   assign f_load  = |(fetch_instr_i & LOAD_MASK);
   assign f_lsu   = f_load | (|(fetch_instr_i & STORE_MASK));

   assign exec_opcode_valid_o = ir_valid_q & ~ir_lsu;
   assign lsu_valid_o         = ir_valid_q & ir_lsu;

   // an LSU op the LSU has not taken must stay put in the issue register
   assign stall  = lsu_valid_o & ~lsu_accept_i;
   assign hazard = sb_q[f_ra] | sb_q[f_rb] | sb_q[f_rd]
                 | (f_lsu & (lsu_busy_q | lsu_valid_o))
                 | (!SUPPORT_FWD & exec_opcode_valid_o & (ir_rd != 5'd0) & ((ir_rd == f_ra) | (ir_rd == f_rb)))
                 | stall | (state_q == ST_HOLD);

   // a redirect always consumes (drops) the fetch slot once running
   assign fetch_accept_o = (state_q != ST_BOOT) & (branch_request_i | (fetch_valid_i & ~hazard));
   assign ir_load_en     = fetch_accept_o & fetch_valid_i & ~branch_request_i;
   assign ir_hold        = stall & ((state_q == ST_HOLD) | ~branch_request_i);

   assign branch_request_o = branch_request_i;
   assign branch_pc_o      = branch_pc_i;

   assign ra_op = (SUPPORT_FWD && ir_ra != 5'd0 && exec_wb_idx_i == ir_ra) ? exec_wb_value_i : rf_q[ir_ra];
   assign rb_op = (SUPPORT_FWD && ir_rb != 5'd0 && exec_wb_idx_i == ir_rb) ? exec_wb_value_i : rf_q[ir_rb];

   assign exec_instr_o      = ir_instr_q;
   assign exec_opcode_o     = ir_opcode_q;
   assign exec_pc_o         = ir_pc_q;
   assign exec_rd_idx_o     = ir_rd;
   assign exec_ra_idx_o     = ir_ra;
   assign exec_rb_idx_o     = ir_rb;
   assign exec_ra_operand_o = ra_op;
   assign exec_rb_operand_o = rb_op;
   assign lsu_instr_o       = ir_instr_q;
   assign lsu_opcode_o      = ir_opcode_q;
   assign lsu_pc_o          = ir_pc_q;
   assign lsu_rd_idx_o      = ir_rd;
   assign lsu_ra_operand_o  = ra_op;
   assign lsu_rb_operand_o  = rb_op;

   // next state: boot waits for the first redirect, LSU backpressure parks in HOLD
   always_comb begin
      state_d = state_q;
      if (state_q == ST_BOOT && branch_request_i) state_d = ST_RUN;
      else if (state_q == ST_RUN && stall && !branch_request_i) state_d = ST_HOLD;
      else if (state_q == ST_HOLD && lsu_accept_i) state_d = ST_RUN;
   end

   // scoreboard: load writeback clears, a load entering the issue register sets (set wins)
   always_comb begin
      sb_d = sb_q & ~(lsu_wb_valid_i ? (32'd1 << lsu_wb_idx_i) : 32'd0);
      if (ir_load_en && f_load) sb_d[f_rd] = 1'b1;
      sb_d[0] = 1'b0;
   end

   // control state: FSM, scoreboard and outstanding-load flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_BOOT;
         sb_q       <= '0;
         lsu_busy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sb_q       <= sb_d;
         lsu_busy_q <= (lsu_valid_o & lsu_accept_i & ir_load) | (lsu_busy_q & ~lsu_wb_valid_i);
      end
   end

   // issue register: load on accept, hold while the LSU stalls, otherwise empty
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ir_valid_q  <= 1'b0;
         ir_pc_q     <= '0;
         ir_opcode_q <= '0;
         ir_instr_q  <= '0;
      end else begin
         ir_valid_q <= ir_hold | ir_load_en;
         if (ir_load_en) begin
            ir_pc_q     <= fetch_pc_i;
            ir_opcode_q <= fetch_opcode_i;
            ir_instr_q  <= fetch_instr_i;
         end
      end
   end

   // register file with exec and LSU write ports; x0 is never written
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         if (exec_wb_idx_i != 5'd0) rf_q[exec_wb_idx_i] <= exec_wb_value_i;
         if (lsu_wb_valid_i && lsu_wb_idx_i != 5'd0) rf_q[lsu_wb_idx_i] <= lsu_wb_value_i;
      end
   end
endmodule
